ntt_coeff_loader: RTL and testbench

Serial-to-parallel input stage for the NTT/INTT processing unit. It accepts one N-bit coefficient per cycle over a valid/ready stream and reduces each coefficient into [0, Q). It packs D coefficients into a D*N-bit frame using a two-entry ping-pong buffer, then presents the frame with its transform mode on the wide coefficient bus that feeds the processing unit.

---
 rtl/ntt_pkg.sv | 22 ++
 rtl/mod_cond_sub.sv | 12 +
 rtl/ntt_coeff_loader.sv | 125 ++++++++++++
 tb/tb_ntt_coeff_loader.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared constants and helpers for the NTT/INTT datapath.
package ntt_pkg;

    localparam int unsigned N    = 17;
    localparam int unsigned D    = 16;
    localparam int unsigned Q    = 65537;
    localparam int unsigned NINV = 61441;
    localparam int unsigned LOGD = $clog2(D);

    // Reverse the low 'width' bits of value; upper bits come back zero.
    function automatic logic [31:0] bitrev(input logic [31:0] value, input int unsigned width);
        logic [31:0] r;
        r = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < width) begin
                r[5'(i)] = value[5'(width - 1 - i)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mod_cond_sub.sv
// Single conditional subtract of Q; exact for inputs below 2*Q.
module mod_cond_sub #(
    parameter int unsigned N = ntt_pkg::N,
    parameter int unsigned Q = ntt_pkg::Q
) (
    input  logic [N-1:0] din,
    output logic [N-1:0] dout_c
);

    assign dout_c = (din >= N'(Q)) ? din - N'(Q) : din;

endmodule

// File: rtl/ntt_coeff_loader.sv
// Serial coefficient stream to D-lane frames through a ping-pong buffer,
// with modular reduction on the way in.
module ntt_coeff_loader #(
    parameter int unsigned N      = ntt_pkg::N,
    parameter int unsigned D      = ntt_pkg::D,
    parameter int unsigned Q      = ntt_pkg::Q,
    parameter int unsigned BITREV = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   in_data,
    input  logic           in_valid,
    input  logic           in_last,
    input  logic           in_inv,
    output logic           in_ready,
    output logic [D*N-1:0] a,
    output logic           out_inv,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           frame_err
);

    localparam int unsigned LOGD = $clog2(D);
    localparam int unsigned W    = D * N;

    logic [LOGD-1:0] idx_q, idx_d;
    logic            wr_ptr_q, wr_ptr_d;
    logic            rd_ptr_q, rd_ptr_d;
    logic [1:0]      full_q, full_d;
    logic [1:0]      inv_q, inv_d;
    logic            frame_err_q, frame_err_d;
    logic [W-1:0]    buf_q [2];
    logic [W-1:0]    buf_d [2];

    logic [N-1:0]    red_c;
    logic [LOGD-1:0] wr_lane_c;
    logic [D-1:0]    lane_we_c;
    logic            accept_c;
    logic            read_c;

    mod_cond_sub #(.N(N), .Q(Q)) u_red (
        .din    (in_data),
        .dout_c (red_c)
    );

    assign in_ready  = ~rst & ~full_q[wr_ptr_q];
    assign accept_c  = in_valid & in_ready;
    assign out_valid = full_q[rd_ptr_q];
    assign read_c    = out_valid & out_ready;
    assign a         = buf_q[rd_ptr_q];
    assign out_inv   = inv_q[rd_ptr_q];
    assign frame_err = frame_err_q;

    assign wr_lane_c = (BITREV != 0) ? LOGD'(ntt_pkg::bitrev(32'(idx_q), LOGD)) : idx_q;

    // One-hot lane write enable for the coefficient being accepted.
    for (genvar l = 0; l < D; l++) begin : g_lane_we
        assign lane_we_c[l] = accept_c & (wr_lane_c == LOGD'(l));
    end

    always_comb begin
        idx_d       = idx_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        full_d      = full_q;
        inv_d       = inv_q;
        frame_err_d = frame_err_q;
        buf_d[0]    = buf_q[0];
        buf_d[1]    = buf_q[1];

        // A read always targets a full buffer and a write a non-full one,
        // so both can act in the same cycle without colliding.
        if (read_c) begin
            full_d[rd_ptr_q] = 1'b0;
            rd_ptr_d         = ~rd_ptr_q;
        end

        for (int b = 0; b < 2; b++) begin
            for (int l = 0; l < int'(D); l++) begin
                if (lane_we_c[l] && (wr_ptr_q == b[0])) begin
                    buf_d[b][N*l +: N] = red_c;
                end
            end
        end

        if (accept_c) begin
            if (idx_q == '0) begin
                inv_d[wr_ptr_q] = in_inv;
            end
            if (idx_q == LOGD'(D - 1)) begin
                full_d[wr_ptr_q] = 1'b1;
                wr_ptr_d         = ~wr_ptr_q;
                idx_d            = '0;
            end else if (in_last) begin
                frame_err_d = 1'b1;
                idx_d       = '0;
            end else begin
                idx_d = idx_q + LOGD'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q       <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            full_q      <= '0;
            inv_q       <= '0;
            frame_err_q <= 1'b0;
            buf_q[0]    <= '0;
            buf_q[1]    <= '0;
        end else begin
            idx_q       <= idx_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            full_q      <= full_d;
            inv_q       <= inv_d;
            frame_err_q <= frame_err_d;
            buf_q[0]    <= buf_d[0];
            buf_q[1]    <= buf_d[1];
        end
    end

endmodule

// File: tb/tb_ntt_coeff_loader.sv
// Directed test of ntt_coeff_loader in natural and bit-reversed lane order.
module tb_ntt_coeff_loader;

    localparam int unsigned N = 17;
    localparam int unsigned D = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   in_data;
    logic           in_valid, in_last, in_inv, out_ready;
    logic           in_ready, out_inv, out_valid, frame_err;
    logic [D*N-1:0] a;
    logic           in_ready_br, out_inv_br, out_valid_br, frame_err_br;
    logic [D*N-1:0] a_br;

    int             n_checks = 0;
    int             n_fail   = 0;
    logic           acc_seen;
    logic [D*N-1:0] exp_a;
    int             acc_cnt;

    always #5 clk = ~clk;

    ntt_coeff_loader #(.N(N), .D(D), .Q(65537), .BITREV(0)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_inv(in_inv), .in_ready(in_ready), .a(a),
        .out_inv(out_inv), .out_valid(out_valid), .out_ready(out_ready),
        .frame_err(frame_err)
    );

    ntt_coeff_loader #(.N(N), .D(D), .Q(65537), .BITREV(1)) dut_br (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_inv(in_inv), .in_ready(in_ready_br), .a(a_br),
        .out_inv(out_inv_br), .out_valid(out_valid_br), .out_ready(out_ready),
        .frame_err(frame_err_br)
    );

    task automatic check(input string tag, input logic [D*N-1:0] obs, input logic [D*N-1:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Advance one cycle; record whether the offered coefficient was taken.
    task automatic step();
        @(negedge clk);
        acc_seen = in_valid & in_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [N-1:0] d, input logic inv, input logic last);
        in_data  = d;
        in_inv   = inv;
        in_last  = last;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("accept", D*N'(acc_seen), D*N'(1));
    endtask

    task automatic read_frame();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_data = '0; in_valid = 1'b0; in_last = 1'b0;
        in_inv = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("ready_in_rst", D*N'(in_ready), '0);
        rst = 1'b0;
        #1;
        check("rst_ready", D*N'(in_ready), D*N'(1));
        check("rst_valid", D*N'(out_valid), '0);
        check("rst_a", a, '0);
        check("rst_err", D*N'(frame_err), '0);

        // Basic frame 0..15
        for (int k = 0; k < 16; k++) send(N'(k), 1'b0, k == 15);
        exp_a = '0;
        for (int k = 0; k < 16; k++) exp_a[N*k +: N] = N'(k);
        check("basic_valid", D*N'(out_valid), D*N'(1));
        check("basic_inv", D*N'(out_inv), '0);
        check("basic_a", a, exp_a);
        check("br_lane1", D*N'(a_br[N*1 +: N]), D*N'(8));
        check("br_lane8", D*N'(a_br[N*8 +: N]), D*N'(1));
        check("br_lane15", D*N'(a_br[N*15 +: N]), D*N'(15));
        read_frame();
        check("basic_drained", D*N'(out_valid), '0);

        // Reduction frame
        send(N'(65536), 1'b1, 1'b0);
        send(N'(65537), 1'b1, 1'b0);
        send(N'(131071), 1'b1, 1'b0);
        for (int k = 3; k < 16; k++) send(N'(k), 1'b1, k == 15);
        check("red_lane0", D*N'(a[N*0 +: N]), D*N'(65536));
        check("red_lane1", D*N'(a[N*1 +: N]), D*N'(0));
        check("red_lane2", D*N'(a[N*2 +: N]), D*N'(65534));
        check("red_inv", D*N'(out_inv), D*N'(1));
        read_frame();

        // Backpressure: offer three frames with out_ready low
        acc_cnt  = 0;
        in_valid = 1'b1;
        for (int c = 0; c < 60; c++) begin
            in_data = N'(100 * (acc_cnt / 16 + 1) + acc_cnt % 16);
            in_inv  = (acc_cnt / 16) == 0;
            in_last = (acc_cnt % 16) == 15;
            step();
            if (acc_seen) acc_cnt++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("bp_accepts", D*N'(acc_cnt), D*N'(32));
        check("bp_ready_low", D*N'(in_ready), '0);
        check("bp_f1_valid", D*N'(out_valid), D*N'(1));
        check("bp_f1_inv", D*N'(out_inv), D*N'(1));
        check("bp_f1_lane0", D*N'(a[N*0 +: N]), D*N'(100));
        check("bp_f1_lane15", D*N'(a[N*15 +: N]), D*N'(115));
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_no_comb_ready", D*N'(in_ready), '0);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_ready_back", D*N'(in_ready), D*N'(1));
        check("bp_f2_valid", D*N'(out_valid), D*N'(1));
        check("bp_f2_inv", D*N'(out_inv), '0);
        check("bp_f2_lane0", D*N'(a[N*0 +: N]), D*N'(200));
        check("bp_f2_lane15", D*N'(a[N*15 +: N]), D*N'(215));
        read_frame();
        check("bp_empty", D*N'(out_valid), '0);

        // Framing error at index 5, then a clean frame
        for (int k = 0; k < 6; k++) send(N'(400 + k), 1'b1, k == 5);
        check("err_set", D*N'(frame_err), D*N'(1));
        check("err_no_valid", D*N'(out_valid), '0);
        for (int k = 0; k < 16; k++) send(N'(500 + k), 1'b0, k == 15);
        check("err_clean_valid", D*N'(out_valid), D*N'(1));
        check("err_clean_lane0", D*N'(a[N*0 +: N]), D*N'(500));
        check("err_clean_lane15", D*N'(a[N*15 +: N]), D*N'(515));
        check("err_clean_inv", D*N'(out_inv), '0);
        check("err_sticky", D*N'(frame_err), D*N'(1));

        // Reset mid-frame with a frame pending
        for (int k = 0; k < 9; k++) send(N'(600 + k), 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        check("mrst_a", a, '0);
        check("mrst_valid", D*N'(out_valid), '0);
        check("mrst_inv", D*N'(out_inv), '0);
        check("mrst_err", D*N'(frame_err), '0);
        check("mrst_ready", D*N'(in_ready), '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("post_rst_ready", D*N'(in_ready), D*N'(1));
        check("post_rst_valid", D*N'(out_valid), '0);
        for (int k = 0; k < 16; k++) send(N'(700 + k), 1'b1, k == 15);
        check("post_rst_frame", D*N'(out_valid), D*N'(1));
        check("post_rst_lane0", D*N'(a[N*0 +: N]), D*N'(700));
        check("post_rst_inv", D*N'(out_inv), D*N'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
